// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the parameterised register file.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package reg_file_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  // Address width needed to index 'depth' entries; a depth below 2 still gets one bit.
  function automatic int addr_w_f(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/reg_entry.sv
// One register-file entry: a data word plus its valid bit.
// Latency: write/clear take effect at the next rising edge.
// Backpressure: none, every write/clear is accepted immediately.
module reg_entry
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             vld_o
);

  logic [WIDTH-1:0] dat_q;
  logic             vld_q;
  logic             vld_d;

  // Valid bit next state: clear wins over a same-cycle write.
  always_comb begin
    vld_d = vld_q;
    if (clr_i)        vld_d = 1'b0;
    else if (wr_en_i) vld_d = 1'b1;
  end

  // Valid bit register; only this bit needs reset since invalid words are never shown.
  always_ff @(posedge clk) begin
    if (!reset_n) vld_q <= 1'b0;
    else          vld_q <= vld_d;
  end

  // Storage word; a write is dropped when reset or clear is active the same cycle.
  always_ff @(posedge clk) begin
    if (reset_n && wr_en_i && !clr_i) dat_q <= wr_dat_i;
  end

  assign dat_o = dat_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/param_reg_file.sv
// Register file with per-entry valid bits, write-first bypass, bulk clear and valid counter.
// Latency: read data/valid/error registered, 1 cycle after read_enable.
// Backpressure: none, reads and writes are accepted every cycle.
module param_reg_file
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = addr_w_f(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic              clear,
  output logic [WIDTH-1:0]  data_out,
  output logic              read_valid,
  output logic              read_error,
  output logic [ADDR_W:0]   valid_count
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] word [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] wr_sel;

  logic             wr_in_range;
  logic             wr_acc;
  logic             bypass;
  logic [WIDTH-1:0] rd_word;
  logic             rd_vld;
  logic             wr_tgt_vld;

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rv_q, rv_d;
  logic             rerr_q, rerr_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;

  assign wr_in_range = {1'b0, write_addr} < DEPTH_W;
  assign wr_acc      = write_enable && wr_in_range && !clear;
  assign bypass      = write_enable && wr_in_range && (read_addr == write_addr);

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign wr_sel[g] = wr_acc && (write_addr == ADDR_W'(g));
    reg_entry #(.WIDTH(WIDTH)) u_entry (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en_i  (wr_sel[g]),
      .clr_i    (clear),
      .wr_dat_i (data_in),
      .dat_o    (word[g]),
      .vld_o    (vld[g])
    );
  end

  // Read mux and write-target valid lookup; out-of-range addresses match nothing and read as invalid.
  always_comb begin
    rd_word    = '0;
    rd_vld     = 1'b0;
    wr_tgt_vld = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (read_addr == ADDR_W'(i)) begin
        rd_word = word[i];
        rd_vld  = vld[i];
      end
      if (write_addr == ADDR_W'(i)) wr_tgt_vld = vld[i];
    end
  end

  // Read response and valid counter next state; bypass applies even when the write is cleared away.
  always_comb begin
    dout_d = dout_q;
    rerr_d = rerr_q;
    rv_d   = 1'b0;
    cnt_d  = cnt_q;
    if (read_enable) begin
      rv_d = 1'b1;
      if (bypass) begin
        dout_d = data_in;
        rerr_d = 1'b0;
      end else if (rd_vld) begin
        dout_d = rd_word;
        rerr_d = 1'b0;
      end else begin
        dout_d = '0;
        rerr_d = 1'b1;
      end
    end
    if (clear)                     cnt_d = '0;
    else if (wr_acc && !wr_tgt_vld) cnt_d = cnt_q + 1'b1;
  end

  // Output and counter registers; reset overrides any in-flight read.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout_q <= '0;
      rv_q   <= 1'b0;
      rerr_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      dout_q <= dout_d;
      rv_q   <= rv_d;
      rerr_q <= rerr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_out    = dout_q;
  assign read_valid  = rv_q;
  assign read_error  = rerr_q;
  assign valid_count = cnt_q;

endmodule

// File: tb/tb_param_reg_file.sv
// Bench for param_reg_file: default (16x8) and DEPTH=6 instances share stimulus.
// Latency: outputs compared every cycle against a behavioural model.
// Backpressure: n/a.
module tb_param_reg_file;

  logic        clk;
  logic        reset_n;
  logic        write_enable;
  logic [2:0]  write_addr;
  logic [15:0] data_in;
  logic        read_enable;
  logic [2:0]  read_addr;
  logic        clear;

  logic [15:0] dout0, dout6;
  logic        rv0, rv6, rerr0, rerr6;
  logic [3:0]  vc0, vc6;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  param_reg_file u0 (
    .clk(clk), .reset_n(reset_n), .write_enable(write_enable), .write_addr(write_addr),
    .data_in(data_in), .read_enable(read_enable), .read_addr(read_addr), .clear(clear),
    .data_out(dout0), .read_valid(rv0), .read_error(rerr0), .valid_count(vc0)
  );

  param_reg_file #(.WIDTH(16), .DEPTH(6)) u6 (
    .clk(clk), .reset_n(reset_n), .write_enable(write_enable), .write_addr(write_addr),
    .data_in(data_in), .read_enable(read_enable), .read_addr(read_addr), .clear(clear),
    .data_out(dout6), .read_valid(rv6), .read_error(rerr6), .valid_count(vc6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: index 0 models DEPTH=8, index 1 models DEPTH=6.
  int          dep [2] = '{8, 6};
  logic [15:0] mmem [2][8];
  bit          mvld [2][8];
  logic [15:0] mdout [2];
  bit          mrv [2];
  bit          mre [2];

  initial begin
    for (int m = 0; m < 2; m++) begin
      mdout[m] = '0;
      mrv[m]   = 0;
      mre[m]   = 0;
      for (int a = 0; a < 8; a++) mvld[m][a] = 0;
    end
  end

  function automatic int pop(input int m);
    int n = 0;
    for (int a = 0; a < dep[m]; a++) n += int'(mvld[m][a]);
    return n;
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (!reset_n) begin
        for (int a = 0; a < 8; a++) mvld[m][a] = 0;
        mdout[m] = '0;
        mrv[m]   = 0;
        mre[m]   = 0;
      end else begin
        mrv[m] = read_enable;
        if (read_enable) begin
          if (write_enable && int'(write_addr) < dep[m] && read_addr == write_addr) begin
            mdout[m] = data_in;
            mre[m]   = 0;
          end else if (int'(read_addr) < dep[m] && mvld[m][read_addr]) begin
            mdout[m] = mmem[m][read_addr];
            mre[m]   = 0;
          end else begin
            mdout[m] = '0;
            mre[m]   = 1;
          end
        end
        if (clear) begin
          for (int a = 0; a < 8; a++) mvld[m][a] = 0;
        end else if (write_enable && int'(write_addr) < dep[m]) begin
          mmem[m][write_addr] = data_in;
          mvld[m][write_addr] = 1;
        end
      end
    end
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("u0.data_out",    64'(dout0), 64'(mdout[0]));
        chk("u0.read_valid",  64'(rv0),   64'(mrv[0]));
        chk("u0.read_error",  64'(rerr0), 64'(mre[0]));
        chk("u0.valid_count", 64'(vc0),   64'(pop(0)));
        chk("u6.data_out",    64'(dout6), 64'(mdout[1]));
        chk("u6.read_valid",  64'(rv6),   64'(mrv[1]));
        chk("u6.read_error",  64'(rerr6), 64'(mre[1]));
        chk("u6.valid_count", 64'(vc6),   64'(pop(1)));
      end
    end
  end

  task automatic cyc(input bit rn, input bit we, input logic [2:0] wa, input logic [15:0] d,
                     input bit re, input logic [2:0] ra, input bit cl);
    reset_n      = rn;
    write_enable = we;
    write_addr   = wa;
    data_in      = d;
    read_enable  = re;
    read_addr    = ra;
    clear        = cl;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 0; write_enable = 0; write_addr = '0; data_in = '0;
    read_enable = 0; read_addr = '0; clear = 0;
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk_on = 1;
    chk("reset.valid_count", 64'(vc0), 64'd0);
    chk("reset.read_valid",  64'(rv0), 64'd0);

    // Read of an unwritten entry after reset.
    cyc(1, 0, 0, 0, 1, 3, 0);
    chk("rd3.data_out",    64'(dout0), 64'd0);
    chk("rd3.read_valid",  64'(rv0),   64'd1);
    chk("rd3.read_error",  64'(rerr0), 64'd1);
    chk("rd3.valid_count", 64'(vc0),   64'd0);

    // Write then read back.
    cyc(1, 1, 2, 16'hA5A5, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 2, 0);
    chk("rd2.data_out",    64'(dout0), 64'hA5A5);
    chk("rd2.read_error",  64'(rerr0), 64'd0);
    chk("rd2.valid_count", 64'(vc0),   64'd1);

    // Write-first bypass on a previously invalid entry.
    cyc(1, 1, 5, 16'h1234, 1, 5, 0);
    chk("byp.data_out",    64'(dout0), 64'h1234);
    chk("byp.read_error",  64'(rerr0), 64'd0);
    chk("byp.valid_count", 64'(vc0),   64'd2);

    // Fill all entries, then clear together with a write.
    for (int i = 0; i < 8; i++) cyc(1, 1, 3'(i), 16'h0100 + 16'(i), 0, 0, 0);
    chk("fill.u0.valid_count", 64'(vc0), 64'd8);
    chk("fill.u6.valid_count", 64'(vc6), 64'd6);
    cyc(1, 1, 0, 16'hBEEF, 0, 0, 1);
    chk("clr.valid_count", 64'(vc0), 64'd0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk("clr.rd0.read_error", 64'(rerr0), 64'd1);
    chk("clr.rd0.data_out",   64'(dout0), 64'd0);

    // Out-of-range write and read on the DEPTH=6 instance.
    cyc(1, 1, 1, 16'h1111, 0, 0, 0);
    cyc(1, 1, 7, 16'h7777, 0, 0, 0);
    chk("oor.u6.valid_count", 64'(vc6), 64'd1);
    cyc(1, 0, 0, 0, 1, 7, 0);
    chk("oor.u6.read_error",  64'(rerr6), 64'd1);
    chk("oor.u6.read_valid",  64'(rv6),   64'd1);
    chk("oor.u6.data_out",    64'(dout6), 64'd0);
    chk("oor.u6.valid_count2", 64'(vc6),  64'd1);
    chk("oor.u0.data_out",    64'(dout0), 64'h7777);

    // Read in flight, reset on the following edge.
    cyc(1, 0, 0, 0, 1, 1, 0);
    chk("rip.data_out", 64'(dout0), 64'h1111);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rip.read_valid",  64'(rv0),   64'd0);
    chk("rip.data_out2",   64'(dout0), 64'd0);
    chk("rip.valid_count", 64'(vc0),   64'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] wa;
      logic [2:0] ra;
      wa = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      cyc($urandom_range(0, 63) != 0, 1'($urandom), wa, 16'($urandom),
          1'($urandom), ra, $urandom_range(0, 15) == 0);
    end
    cyc(1, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width in bits, legal 1..64.
REQ-002 SHALL have parameter DEPTH, default 8: number of entries, legal 2..256, need not be a power of two.
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH): address width, derived and not overridden.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port write_enable, input, 1 bit: write request this cycle.
REQ-007 SHALL have port write_addr, input, ADDR_W bits: target entry of the write.
REQ-008 SHALL have port data_in, input, WIDTH bits: write data.
REQ-009 SHALL have port read_enable, input, 1 bit: read request this cycle.
REQ-010 SHALL have port read_addr, input, ADDR_W bits: source entry of the read.
REQ-011 SHALL have port clear, input, 1 bit: synchronous invalidate of all entries.
REQ-012 SHALL have port data_out, output, WIDTH bits: registered read data.
REQ-013 SHALL have port read_valid, output, 1 bit: data_out updated by a read accepted last cycle.
REQ-014 SHALL have port read_error, output, 1 bit: the last accepted read hit an invalid or out-of-range entry.
REQ-015 SHALL have port valid_count, output, ADDR_W+1 bits: number of currently valid entries.

Function
REQ-016 SHALL keep DEPTH storage words plus one valid bit per entry.
REQ-017 SHALL, on write_enable with write_addr < DEPTH, store data_in and set that entry's valid bit at the next edge.
REQ-018 SHALL ignore writes with write_addr >= DEPTH, with no state change.
REQ-019 SHALL, on read_enable, update data_out, read_valid and read_error at the next edge, giving 1-cycle latency.
REQ-020 SHALL, on a read of a valid in-range entry, drive data_out = stored word, read_valid=1, read_error=0.
REQ-021 SHALL, on a read of an invalid or out-of-range entry, drive data_out = 0, read_valid=1, read_error=1.
REQ-022 SHALL, when read_enable=0, hold data_out and read_error, and drive read_valid=0 next cycle.
REQ-023 SHALL, on a same-cycle write and read of the same in-range address, return data_in (write-first bypass), read_error=0.
REQ-024 SHALL, on a same-cycle write and read of different addresses, perform both independently.
REQ-025 SHALL NOT let a write affect data_out unless REQ-023 applies.
REQ-026 SHALL, on clear=1, clear all valid bits next edge while leaving stored words unchanged.
REQ-027 SHALL give clear priority over a same-cycle write, so the write is discarded.
REQ-028 SHALL, on a same-cycle clear and read, return the pre-clear contents, or the REQ-023 bypass value, for that read.
REQ-029 SHALL increment valid_count only when a write sets a previously clear valid bit.
REQ-030 SHALL leave valid_count unchanged on an overwrite, drive it to 0 on clear, and never exceed DEPTH.

Reset
REQ-031 SHALL, when reset_n=0 at a rising edge, clear all valid bits and drive data_out=0, read_valid=0, read_error=0, valid_count=0.
REQ-032 SHALL give reset priority over clear, write and read in the same cycle.
REQ-033 SHALL NOT require storage words to be reset; an invalid entry is never observable because of REQ-021.
REQ-034 SHALL, when reset is asserted mid-operation, discard any read in flight so that read_valid=0 on the cycle after reset.

Structure
REQ-035 SHALL place the default WIDTH/DEPTH constants and the ADDR_W derivation function in shared package reg_file_pkg.
REQ-036 SHALL use one natural sub-module, reg_entry, holding one WIDTH word plus its valid bit with write, clear and reset inputs, instantiated DEPTH times.
REQ-037 SHALL keep read mux, bypass, error and counter logic in the top level.

Verification
REQ-038 SHALL cover: reset_n=0 for 2 cycles, then read addr 3 -> data_out=0, read_valid=1, read_error=1, valid_count=0.
REQ-039 SHALL cover: write 16'hA5A5 to addr 2, then read addr 2 next cycle -> data_out=16'hA5A5, read_error=0, valid_count=1.
REQ-040 SHALL cover: same-cycle write 16'h1234 and read of addr 5 (previously invalid) -> data_out=16'h1234, read_error=0 next cycle.
REQ-041 SHALL cover: write all 8 entries, then assert clear together with a write to addr 0 -> valid_count=0, and a read of addr 0 gives read_error=1.
REQ-042 SHALL cover: DEPTH=6, write addr 7 then read addr 7 -> no state change, read_error=1, valid_count unchanged.
REQ-043 SHALL cover: read issued, reset_n=0 on the following edge -> read_valid=0 and data_out=0 after reset.
